// File: rtl/opc7_intc.sv
// opc7_intc: memory-mapped interrupt controller for the OPC7 CPU.
// Synchronises, latches, masks and routes sources onto two active-low lines.
module opc7_intc #(
    parameter int          NSRC = 8,
    parameter logic [19:0] BASE = 20'h0FF00
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic            clken,
    input  logic [19:0]     address,
    input  logic [31:0]     wdata,
    input  logic            rnw,
    input  logic            vio,
    input  logic [NSRC-1:0] irq_in,
    output logic [31:0]     rdata,
    output logic [1:0]      int_b
);

    localparam logic [2:0] OFF_PEND  = 3'd0;
    localparam logic [2:0] OFF_MASK  = 3'd1;
    localparam logic [2:0] OFF_LEVEL = 3'd2;
    localparam logic [2:0] OFF_MODE  = 3'd3;
    localparam logic [2:0] OFF_ID    = 3'd4;
    localparam logic [2:0] OFF_SWSET = 3'd5;

    logic            sel;
    logic [2:0]      off;
    logic            we;
    logic [NSRC-1:0] wsrc;

    logic [NSRC-1:0] s1, s2, s3;
    logic [NSRC-1:0] pend, mask, level, mode;
    logic [NSRC-1:0] rise, w1c, swset, pend_nxt;
    logic [NSRC-1:0] active, act1, act0;
    logic [3:0]      idx1, idx0;
    logic [31:0]     id;

    logic unused;
    assign unused = ^wdata[31:NSRC];

    assign sel  = vio & (address[19:3] == BASE[19:3]);
    assign off  = address[2:0];
    assign we   = clken & sel & ~rnw;
    assign wsrc = wdata[NSRC-1:0];

    assign rise  = s2 & ~s3;
    assign w1c   = (we && off == OFF_PEND)  ? wsrc : '0;
    assign swset = (we && off == OFF_SWSET) ? wsrc : '0;

    // Edge sources: set beats clear. Level sources mirror s2.
    assign pend_nxt = (mode & ((pend & ~w1c) | rise | swset))
                    | (~mode & s2);

    assign active = pend & mask;
    assign act1   = active & level;
    assign act0   = active & ~level;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            pend  <= '0;
            mask  <= '0;
            level <= '0;
            mode  <= '0;
            int_b <= 2'b11;
        end else if (clken) begin
            s1    <= irq_in;
            s2    <= s1;
            s3    <= s2;
            pend  <= pend_nxt;
            if (we && off == OFF_MASK)  mask  <= wsrc;
            if (we && off == OFF_LEVEL) level <= wsrc;
            if (we && off == OFF_MODE)  mode  <= wsrc;
            int_b <= {~|act1, ~|act0};
        end
    end

    // Descending scan leaves the lowest active index in each group.
    always_comb begin
        idx1 = '0;
        idx0 = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (act1[i]) idx1 = 4'(i);
            if (act0[i]) idx0 = 4'(i);
        end
        id = '0;
        if (|act1)
            id = {1'b1, 26'b0, 1'b1, idx1};
        else if (|act0)
            id = {1'b1, 26'b0, 1'b0, idx0};
    end

    always_comb begin
        rdata = '0;
        if (sel && rnw) begin
            unique case (off)
                OFF_PEND:  rdata = 32'(pend);
                OFF_MASK:  rdata = 32'(mask);
                OFF_LEVEL: rdata = 32'(level);
                OFF_MODE:  rdata = 32'(mode);
                OFF_ID:    rdata = id;
                default:   rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_opc7_intc.sv
// tb_opc7_intc: scoreboard bench for opc7_intc.
// Expected values are queued with stimulus and popped at sampling.
module tb_opc7_intc;

    localparam int          NSRC = 8;
    localparam logic [19:0] BASE = 20'h0FF00;

    logic        clk;
    logic        reset_b;
    logic        clken;
    logic [19:0] address;
    logic [31:0] wdata;
    logic        rnw;
    logic        vio;
    logic [7:0]  irq_in;
    logic [31:0] rdata;
    logic [1:0]  int_b;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_err;

    opc7_intc #(.NSRC(NSRC), .BASE(BASE)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .clken   (clken),
        .address (address),
        .wdata   (wdata),
        .rnw     (rnw),
        .vio     (vio),
        .irq_in  (irq_in),
        .rdata   (rdata),
        .int_b   (int_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL scoreboard: empty queue, got %h expected entry", got);
        end else begin
            e = sb.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [19:0] a,
                          input logic [31:0] d,
                          input logic v);
        address = a;
        wdata   = d;
        rnw     = 1'b0;
        vio     = v;
        tick();
        vio     = 1'b0;
        rnw     = 1'b1;
    endtask

    task automatic wr(input logic [2:0] o, input logic [31:0] d);
        bus_wr(BASE + 20'(o), d, 1'b1);
    endtask

    task automatic rd_addr(input string tag,
                           input logic [19:0] a,
                           input logic [31:0] exp);
        push(tag, exp);
        address = a;
        rnw     = 1'b1;
        vio     = 1'b1;
        #1;
        pop_cmp(rdata);
        vio     = 1'b0;
    endtask

    task automatic rd(input string tag,
                      input logic [2:0] o,
                      input logic [31:0] exp);
        rd_addr(tag, BASE + 20'(o), exp);
    endtask

    task automatic ib(input string tag, input logic [1:0] exp);
        push(tag, 32'(exp));
        pop_cmp(32'(int_b));
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        reset_b = 1'b0;
        clken   = 1'b1;
        address = '0;
        wdata   = '0;
        rnw     = 1'b1;
        vio     = 1'b0;
        irq_in  = '0;

        // Reset holds everything even while sources toggle.
        for (int i = 0; i < 6; i++) begin
            irq_in = 8'(i[0] ? 8'hFF : 8'h00);
            tick();
        end
        ib("rst_intb", 2'b11);
        rd("rst_mask", 3'd1, 32'h0);
        rd("rst_level", 3'd2, 32'h0);
        rd("rst_mode", 3'd3, 32'h0);
        rd("rst_pend", 3'd0, 32'h0);
        irq_in = '0;
        tick();
        reset_b = 1'b1;
        tick();
        tick();

        // Edge path on source 0.
        wr(3'd3, 32'h01);
        wr(3'd1, 32'h01);
        wr(3'd2, 32'h00);
        irq_in[0] = 1'b1;
        tick();
        tick();
        tick();
        irq_in[0] = 1'b0;
        ib("edge_e3", 2'b11);
        rd("edge_pend_e3", 3'd0, 32'h01);
        tick();
        ib("edge_e4", 2'b10);
        rd("edge_id", 3'd4, 32'h8000_0000);
        wr(3'd0, 32'h01);
        ib("w1c_e", 2'b10);
        rd("w1c_pend", 3'd0, 32'h00);
        tick();
        ib("w1c_e1", 2'b11);
        rd("w1c_id", 3'd4, 32'h0);

        // Priority and ID.
        wr(3'd3, 32'hFF);
        wr(3'd1, 32'hFF);
        wr(3'd2, 32'h20);
        wr(3'd5, 32'h28);
        rd("swset_rd0", 3'd5, 32'h0);
        tick();
        ib("prio_intb", 2'b00);
        rd("prio_id", 3'd4, 32'h8000_0015);
        wr(3'd0, 32'h20);
        tick();
        ib("prio_intb2", 2'b10);
        rd("prio_id2", 3'd4, 32'h8000_0003);
        rd("prio_pend", 3'd0, 32'h08);
        wr(3'd0, 32'hFF);
        tick();
        ib("prio_clr", 2'b11);

        // Level mode on source 2.
        wr(3'd3, 32'h00);
        wr(3'd1, 32'h04);
        wr(3'd2, 32'h00);
        irq_in[2] = 1'b1;
        tick();
        tick();
        tick();
        ib("lvl_e3", 2'b11);
        tick();
        ib("lvl_e4", 2'b10);
        rd("lvl_pend", 3'd0, 32'h04);
        wr(3'd0, 32'h04);
        rd("lvl_w1c", 3'd0, 32'h04);
        irq_in[2] = 1'b0;
        tick();
        tick();
        tick();
        ib("lvl_fall3", 2'b10);
        tick();
        ib("lvl_fall4", 2'b11);

        // Set and clear on the same edge: set wins.
        wr(3'd3, 32'h01);
        wr(3'd1, 32'h01);
        irq_in[0] = 1'b1;
        tick();
        tick();
        wr(3'd0, 32'h01);
        rd("setclr_pend", 3'd0, 32'h01);
        irq_in[0] = 1'b0;
        tick();
        wr(3'd0, 32'h01);
        rd("setclr_after", 3'd0, 32'h00);
        tick();

        // clken low: nothing advances, writes ignored.
        wr(3'd3, 32'h02);
        wr(3'd1, 32'h02);
        tick();
        clken = 1'b0;
        irq_in[1] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        wr(3'd1, 32'hFF);
        rd("clk_pend", 3'd0, 32'h00);
        rd("clk_mask", 3'd1, 32'h02);
        ib("clk_intb", 2'b11);
        clken = 1'b1;
        tick();
        tick();
        tick();
        ib("clk_e3", 2'b11);
        tick();
        ib("clk_e4", 2'b10);

        // Decode: out-of-window and non-I/O accesses.
        bus_wr(BASE + 20'd9, 32'h00, 1'b1);
        rd_addr("dec_b8", BASE + 20'd9, 32'h0);
        bus_wr(BASE + 20'd1, 32'h00, 1'b0);
        rd("dec_vio", 3'd1, 32'h02);
        push("dec_novio", 32'h0);
        address = BASE + 20'd1;
        vio     = 1'b0;
        rnw     = 1'b1;
        #1;
        pop_cmp(rdata);
        ib("dec_intb", 2'b10);

        // Asynchronous reset mid-operation.
        #2;
        reset_b = 1'b0;
        #1;
        ib("async_rst", 2'b11);
        rd("async_pend", 3'd0, 32'h0);
        rd("async_mask", 3'd1, 32'h0);

        if (sb.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/opc7_intc.md
# opc7_intc

Memory-mapped interrupt controller for the OPC7 CPU. It collects up to 16 external interrupt sources, synchronises them, latches them as pending, and applies a mask and a routing choice. It then drives the CPU's two active-low interrupt inputs, int_b[1:0]; int_b[1] selects the higher-priority vector. Software configures and services it over the CPU I/O space (IN/OUT cycles, vio=1), and read data is OR-muxed onto the CPU din bus.

## Interface
- NSRC, 8, number of interrupt sources (1..16)
- BASE, 20'h0FF00, I/O word base address; must be 8-aligned
- clk  input  1  system clock, same as the CPU
- reset_b  input  1  asynchronous active-low reset
- clken  input  1  clock enable; all state advances only on clk edges with clken=1
- address  input  20  CPU address (combinational, valid during the cycle)
- wdata  input  32  CPU dout
- rnw  input  1  CPU read-not-write
- vio  input  1  CPU I/O cycle qualifier
- irq_in  input  NSRC  asynchronous interrupt request lines, active-high
- rdata  output  32  read data, all zeros when not selected
- int_b  output  2  to CPU int_b; int_b[1] is high priority, int_b[0] is low; active-low, registered

## Operation
- Select: sel = vio & (address[19:3] == BASE[19:3]); off = address[2:0].
- Registers (bits NSRC-1:0, upper bits read 0):
  - off 0 PEND: read pending; write-1-to-clear (edge-mode sources only)
  - off 1 MASK: R/W, 1 = enabled
  - off 2 LEVEL: R/W, 1 = routed to int_b[1], 0 = routed to int_b[0]
  - off 3 MODE: R/W, 1 = edge-triggered, 0 = level
  - off 4 ID: read-only. bit31 = valid; bit4 = line (1 = int_b[1]); bits3:0 = index of the lowest-numbered active source. Group int_b[1] is searched first. Reads 0 when nothing is active.
  - off 5 SWSET: write-1-to-set PEND for edge-mode sources; reads 0
  - off 6, 7: read 0; writes ignored
- Synchroniser: each irq_in passes through a 2-flop chain, s1 then s2. A third flop s3 gives rising-edge detection: rise = s2 & ~s3.
- Pending bit, per source:
  - Edge mode: set on rise or SWSET bit; cleared on PEND W1C bit. If set and clear occur on the same edge, set wins.
  - Level mode: PEND is loaded from s2 every enabled edge. W1C and SWSET have no effect.
  - Changing MODE does not alter PEND immediately. A source switched to level mode follows s2 from the next edge.
- Routing: active = PEND & MASK.
  - int_b[1] next = ~|(active & LEVEL)
  - int_b[0] next = ~|(active & ~LEVEL)
- Reads have no side effects, including ID. rdata is combinational: valid when sel & rnw, else 32'h0.
- Writes commit on the clk edge where clken & sel & ~rnw.

## Timing
- Reset (asynchronous, reset_b=0): PEND, MASK, LEVEL, MODE, s1..s3 all 0; int_b = 2'b11. rdata is 0 unless a read is selected, in which case it returns the reset register values.
- Source to int_b latency, counted in clken-qualified edges after irq_in rises (edge mode, masked in):
  - E1: s1
  - E2: s2
  - E3: PEND
  - E4: int_b falls
- Level mode has the same 4-edge latency. int_b rises 4 edges after irq_in falls.
- W1C on edge E clears PEND at E. int_b deasserts at E+1 unless another routed source is active.
- A MASK or LEVEL write on edge E takes effect on int_b at E+1.
- Minimum edge-mode pulse width: 2 enabled edges. A shorter pulse may be lost.
- With clken=0, all state holds and int_b holds. Only rdata tracks the inputs.
- Reset mid-operation: pending interrupts are discarded and int_b returns to 11 immediately, without waiting for a clock.
- Both lines may be low at once. The CPU takes int_b[1] first.

## Test plan
- Reset: hold reset_b=0, toggle irq_in -> int_b=2'b11; reads of MASK, LEVEL, MODE, PEND all return 0.
- Edge path:
  - Setup: MODE=8'h01, MASK=8'h01, LEVEL=0.
  - Stimulus: pulse irq_in[0] for 3 cycles.
  - Required: int_b=2'b10 exactly 4 edges after the rise; ID reads 32'h80000000.
  - Then: write PEND=1 -> int_b=2'b11 one edge later.
- Priority and ID:
  - Setup: MODE=8'hFF, MASK=8'hFF, LEVEL=8'h20; SWSET=8'h28.
  - Required: int_b=2'b00; ID=32'h80000015.
  - Then: clear bit 5 -> ID=32'h80000003, int_b=2'b10.
- Level mode: MODE=0, MASK=8'h04; hold irq_in[2] high -> PEND=8'h04 and int_b=2'b10. A W1C of 4 leaves PEND unchanged. Drop irq_in[2] -> int_b=2'b11 4 edges later.
- Simultaneous set and clear: in edge mode, write PEND=1 on the same edge that rise[0] sets the bit -> PEND[0] remains 1.
- clken and decode:
  - clken=0 for 10 cycles during an irq_in[1] rise -> no state change.
  - An access at BASE+8 or with vio=0 -> rdata=0 and no write takes effect.
  - Asserting reset_b=0 while int_b=2'b10 -> int_b=2'b11 with no clock edge.
